// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles both requester ports and the SDRAM controller side of the arbiter.
interface sram_arbiter_if;
    logic [24:0] a_addr, b_addr, mem_addr;
    logic [7:0]  a_din, a_dout, b_din, b_dout, mem_din, mem_dout;
    logic        a_rd, a_we, a_ack, a_wait;
    logic        b_rd, b_we, b_ack, b_wait;
    logic        mem_rd, mem_we, mem_busy, err;
    modport slave (
        input  a_addr, a_din, a_rd, a_we, b_addr, b_din, b_rd, b_we, mem_dout, mem_busy,
        output a_dout, a_ack, a_wait, b_dout, b_ack, b_wait, mem_addr, mem_din, mem_rd, mem_we, err
    );
    modport master (
        output a_addr, a_din, a_rd, a_we, b_addr, b_din, b_rd, b_we, mem_dout, mem_busy,
        input  a_dout, a_ack, a_wait, b_dout, b_ack, b_wait, mem_addr, mem_din, mem_rd, mem_we, err
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter driving a strobe-held SDRAM controller access,
// with hold/wait/done/gap sequencing and a sticky busy watchdog.
module sram_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int WAIT_MAX    = 1023
) (
    input logic clk_sdram,
    input logic init,
    sram_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, DONE = 3'd3, GAP = 3'd4;
    localparam int CW = $clog2(WAIT_MAX + HOLD_CYCLES + GAP_CYCLES + 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          port, op_we, last_grant;
    logic          a_req, b_req, gnt_b, strobe, wdone;

    assign a_req  = bus.a_rd | bus.a_we;
    assign b_req  = bus.b_rd | bus.b_we;
    // last_grant: 0 = A, 1 = B; on contention the other port wins
    assign gnt_b  = b_req & (~a_req | ~last_grant);
    assign strobe = state == ISSUE || state == WAIT;
    assign wdone  = ~bus.mem_busy || cnt == CW'(WAIT_MAX - 1);

    assign bus.mem_we = strobe & op_we;
    assign bus.mem_rd = strobe & ~op_we;
    assign bus.a_ack  = state == DONE && !port;
    assign bus.b_ack  = state == DONE && port;
    assign bus.a_wait = a_req & ~bus.a_ack;
    assign bus.b_wait = b_req & ~bus.b_ack;

    always_ff @(posedge clk_sdram or posedge init)
        if (init) begin
            state        <= IDLE;
            cnt          <= '0;
            port         <= 1'b0;
            op_we        <= 1'b0;
            last_grant   <= 1'b1;
            bus.err      <= 1'b0;
            bus.a_dout   <= '0;
            bus.b_dout   <= '0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
        end else
            case (state)
                IDLE: if (a_req | b_req) begin
                    port         <= gnt_b;
                    bus.mem_addr <= gnt_b ? bus.b_addr : bus.a_addr;
                    bus.mem_din  <= gnt_b ? bus.b_din : bus.a_din;
                    op_we        <= gnt_b ? bus.b_we : bus.a_we;
                    cnt          <= '0;
                    state        <= ISSUE;
                end
                ISSUE: if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    cnt   <= '0;
                    state <= WAIT;
                end else
                    cnt <= cnt + 1'b1;
                WAIT: if (wdone) begin
                    if (bus.mem_busy) bus.err <= 1'b1;
                    if (!op_we && port) bus.b_dout <= bus.mem_dout;
                    if (!op_we && !port) bus.a_dout <= bus.mem_dout;
                    cnt   <= '0;
                    state <= DONE;
                end else
                    cnt <= cnt + 1'b1;
                DONE: begin
                    last_grant <= port;
                    state      <= GAP;
                end
                GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else
                    cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of grant order, strobe timing, read data, watchdog and reset abort.
module tb_sram_arbiter;
    logic clk = 1'b0, init = 1'b1;
    int   n_chk = 0, n_fail = 0;
    int   we_cnt = 0, rd_cnt = 0, both_cnt = 0;
    int   who, cyc, w0, r0;

    sram_arbiter_if bus();
    sram_arbiter dut (.clk_sdram(clk), .init(init), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        we_cnt   += int'(bus.mem_we);
        rd_cnt   += int'(bus.mem_rd);
        both_cnt += int'(bus.mem_we & bus.mem_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_any(output int w, output int c);
        w = 2;
        c = 0;
        while (w == 2 && c < 2000) begin
            tick();
            c++;
            if (bus.a_ack) w = 0;
            else if (bus.b_ack) w = 1;
        end
    endtask

    initial begin
        {bus.a_addr, bus.a_din, bus.a_rd, bus.a_we} = '0;
        {bus.b_addr, bus.b_din, bus.b_rd, bus.b_we} = '0;
        bus.mem_dout = '0;
        bus.mem_busy = 1'b0;
        tick();
        tick();
        chk("rst_strobes", 32'({bus.mem_rd, bus.mem_we}), 0);
        chk("rst_acks", 32'({bus.a_ack, bus.b_ack, bus.err}), 0);
        chk("rst_dout", 32'({bus.a_dout, bus.b_dout}), 0);
        chk("rst_mem", 32'(bus.mem_addr) | 32'(bus.mem_din), 0);
        init = 1'b0;
        // single A write with busy low
        bus.a_addr = 25'h0001234;
        bus.a_din  = 8'h5A;
        bus.a_we   = 1'b1;
        w0 = we_cnt;
        wait_any(who, cyc);
        chk("wr_who", 32'(who), 0);
        chk("wr_latency", 32'(cyc), 6);
        chk("wr_addr", 32'(bus.mem_addr), 32'h1234);
        chk("wr_din", 32'(bus.mem_din), 32'h5A);
        chk("wr_we_cycles", 32'(we_cnt - w0), 5);
        chk("wr_we_low_at_ack", 32'(bus.mem_we), 0);
        // A re-requests on its ack cycle: must sit out DONE, GAP and reach IDLE first
        bus.a_we = 1'b0;
        bus.a_rd = 1'b1;
        bus.a_din = 8'hFF;
        bus.mem_busy = 1'b1;
        bus.mem_dout = 8'hC3;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) chk("gap_a_wait", 32'(bus.a_wait), 1);
        end while (!bus.mem_rd && cyc < 50);
        chk("gap_cycles_to_rd", 32'(cyc), 4);
        repeat (10) tick();
        chk("rd_busy_no_ack", 32'(bus.a_ack), 0);
        chk("rd_strobe_held", 32'(bus.mem_rd), 1);
        bus.mem_busy = 1'b0;
        wait_any(who, cyc);
        chk("rd_ack_after_busy", 32'(cyc), 1);
        chk("rd_a_dout", 32'(bus.a_dout), 32'hC3);
        chk("rd_b_dout", 32'(bus.b_dout), 0);
        chk("rd_err", 32'(bus.err), 0);
        // rd and we together: write wins
        bus.a_we = 1'b1;
        bus.a_addr = 25'h00ABCDE;
        bus.a_din = 8'h99;
        bus.mem_dout = 8'h11;
        w0 = we_cnt;
        r0 = rd_cnt;
        wait_any(who, cyc);
        chk("rdwe_who", 32'(who), 0);
        chk("rdwe_we_cycles", 32'(we_cnt - w0), 5);
        chk("rdwe_no_rd", 32'(rd_cnt - r0), 0);
        chk("rdwe_din", 32'(bus.mem_din), 32'h99);
        chk("rdwe_dout_kept", 32'(bus.a_dout), 32'hC3);
        // B request withdrawn before it could be granted
        bus.a_rd = 1'b0;
        bus.a_we = 1'b0;
        bus.b_rd = 1'b1;
        w0 = we_cnt;
        r0 = rd_cnt;
        tick();
        bus.b_rd = 1'b0;
        repeat (6) tick();
        chk("drop_no_access", 32'(we_cnt - w0 + rd_cnt - r0), 0);
        chk("drop_no_ack", 32'(bus.b_ack), 0);
        // simultaneous requests after reset alternate starting with A
        init = 1'b1;
        tick();
        init = 1'b0;
        bus.a_we = 1'b1;
        bus.a_addr = 25'h0000010;
        bus.a_din = 8'h22;
        bus.b_we = 1'b1;
        bus.b_addr = 25'h1ABCDEF;
        bus.b_din = 8'h77;
        for (int k = 0; k < 4; k++) begin
            wait_any(who, cyc);
            chk($sformatf("rr_who_%0d", k), 32'(who), 32'(k % 2));
            if (k == 0) chk("rr_b_wait", 32'(bus.b_wait), 1);
            if (k == 1) chk("rr_b_addr", 32'(bus.mem_addr), 32'h1ABCDEF);
            if (k == 1) chk("rr_b_din", 32'(bus.mem_din), 32'h77);
        end
        chk("rr_b_dout_untouched", 32'(bus.b_dout), 0);
        bus.a_we = 1'b0;
        bus.b_we = 1'b0;
        // busy stuck high trips the watchdog
        repeat (4) tick();
        bus.a_rd = 1'b1;
        bus.mem_busy = 1'b1;
        wait_any(who, cyc);
        chk("wd_who", 32'(who), 0);
        chk("wd_latency", 32'(cyc), 1028);
        chk("wd_err", 32'(bus.err), 1);
        bus.a_rd = 1'b0;
        bus.mem_busy = 1'b0;
        repeat (4) tick();
        chk("wd_err_sticky", 32'(bus.err), 1);
        bus.b_we = 1'b1;
        bus.b_addr = 25'h0000005;
        bus.b_din = 8'h33;
        wait_any(who, cyc);
        chk("wd_next_who", 32'(who), 1);
        chk("wd_next_latency", 32'(cyc), 6);
        bus.b_we = 1'b0;
        // reset asserted while waiting on busy
        repeat (4) tick();
        bus.a_rd = 1'b1;
        bus.mem_busy = 1'b1;
        repeat (6) tick();
        chk("abort_pre_rd", 32'(bus.mem_rd), 1);
        init = 1'b1;
        #1;
        chk("abort_rd_low", 32'(bus.mem_rd), 0);
        chk("abort_no_ack", 32'({bus.a_ack, bus.b_ack}), 0);
        chk("abort_err_clr", 32'(bus.err), 0);
        chk("abort_addr_clr", 32'(bus.mem_addr), 0);
        tick();
        init = 1'b0;
        bus.b_rd = 1'b1;
        bus.mem_busy = 1'b0;
        wait_any(who, cyc);
        chk("abort_next_who", 32'(who), 0);
        chk("abort_next_latency", 32'(cyc), 6);
        bus.a_rd = 1'b0;
        bus.b_rd = 1'b0;
        tick();
        chk("never_both_strobes", 32'(both_cnt), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: cycles mem_rd/mem_we are held high per access (min 3).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: cycles both strobes are held low between accesses (min 2).
REQ-003 SHALL have parameter WAIT_MAX, default 1023: busy-wait watchdog limit in cycles.
REQ-004 Clock and reset: one clock, clk_sdram; reset is asynchronous and active-high, named init.
REQ-005 clk_sdram  in  1  sole clock, all logic on rising edge.
REQ-006 init  in  1  asynchronous active-high reset.
REQ-007 a_addr  in  25 | a_din  in  8 | a_rd  in  1 | a_we  in  1: port A (CPU) request; a_rd/a_we are levels.
REQ-008 a_dout  out  8 | a_ack  out  1: port A read data and one-cycle completion pulse.
REQ-009 b_addr  in  25 | b_din  in  8 | b_rd  in  1 | b_we  in  1: port B (loader/DMA) request.
REQ-010 b_dout  out  8 | b_ack  out  1: port B read data and completion pulse.
REQ-011 a_wait  out  1 | b_wait  out  1: high while that port requests and is not yet acked.
REQ-012 mem_addr  out  25 | mem_din  out  8 | mem_rd  out  1 | mem_we  out  1: drive SDRAM controller.
REQ-013 mem_dout  in  8 | mem_busy  in  1: controller read data and busy (cpu_wait) level.
REQ-014 err  out  1: sticky watchdog flag.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, DONE, GAP.
REQ-016 IDLE: port requests if rd|we high; A wins if only A, B if only B; both -> port not granted last (round-robin on last_grant).
REQ-017 On grant SHALL capture addr, din, op (we has priority if rd and we both high) and port id into registers; go ISSUE.
REQ-018 mem_addr/mem_din SHALL come from captured registers only and stay stable from ISSUE through GAP.
REQ-019 ISSUE: assert mem_we (write) or mem_rd (read) for exactly HOLD_CYCLES cycles, then go WAIT with strobe still high.
REQ-020 WAIT: strobe stays high; when mem_busy low, go DONE; watchdog counts WAIT cycles.
REQ-021 Watchdog reaching WAIT_MAX SHALL set err and go DONE (read data then undefined but still delivered).
REQ-022 DONE (one cycle): drop strobe; for reads latch mem_dout into granted port's dout; pulse granted port's ack for one cycle; update last_grant; go GAP.
REQ-023 GAP: hold strobes low for GAP_CYCLES cycles, then IDLE; requests arriving during GAP wait.
REQ-024 x_dout SHALL hold its value until the next read completes on that port; writes do not alter it.
REQ-025 Requests SHALL be held by requester until ack; change of port inputs after grant SHALL be ignored.
REQ-026 Request dropped before grant SHALL produce no access; requester re-asserting after ack SHALL be treated as new.
REQ-027 A port asserting rd/we again on the ack cycle SHALL NOT be regranted until the next IDLE.
REQ-028 mem_rd and mem_we SHALL never be high simultaneously.
REQ-029 Minimum access latency grant->ack = HOLD_CYCLES+2 cycles when mem_busy already low.
REQ-030 err SHALL clear only on init.

Reset
REQ-031 init high SHALL asynchronously force IDLE, counters 0, mem_rd/mem_we/a_ack/b_ack/err 0, a_dout/b_dout/mem_addr/mem_din 0, last_grant=B (A first).
REQ-032 init asserted mid-access SHALL abort it with no ack; first grant after release follows REQ-016.

Verification
REQ-033 A write 0x0001234 data 0x5A, busy low -> mem_we high 5 cycles (4 ISSUE + 1 WAIT), a_ack pulse, 2-cycle gap.
REQ-034 A read 0x0001234, busy high 10 cycles, mem_dout=0xC3 -> a_ack after busy falls, a_dout=0xC3, b_dout unchanged.
REQ-035 A and B request same cycle after reset -> A served first, B next; repeated simultaneous requests alternate A,B,A,B.
REQ-036 a_rd and a_we both high -> write issued, mem_rd never high.
REQ-037 busy stuck high -> after 1023 WAIT cycles err=1, ack issued, next request serviced normally.
REQ-038 init pulsed during WAIT -> strobes low immediately, no ack, err 0, next grant to A.
